hci_source_job_scheduler: RTL and testbench
===========================================

// Module: hci_source_job_scheduler
//
// PURPOSE
// Shares one hci_core_source streamer among NB_REQ requesters, one job at a time.
// - Each requester offers a job descriptor (hci_streamer_ctrl_t) on a valid/ready handshake.
// - Arbitration between requesters is round-robin.
// - For the granted job: latch the descriptor, pulse req_start, hold the config, wait for done.
// - Completion is returned to the owning requester as a one-cycle pulse.
//
// PARAMETERS
// NB_REQ     4   number of requesters (>=2)
// TIMEOUT_W  16  width of the watchdog counter and of timeout_i (used only with the macro)
//
// PORTS
// clk_i            in   1                  clock
// rst_ni           in   1                  async reset, active low
// clear_i          in   1                  sync clear, same effect as reset
// enable_i         in   1                  0 = freeze all state, suppress handshakes
// job_valid_i      in   NB_REQ             per-requester job offer
// job_ready_o      out  NB_REQ             per-requester job accept (one-hot or 0)
// job_ctrl_i       in   NB_REQ x ctrl_t    per-requester descriptor; req_start field ignored
// job_done_o       out  NB_REQ             one-cycle completion pulse to owner
// error_o          out  NB_REQ             one-cycle timeout pulse to owner
// streamer_ctrl_o  out  hci_streamer_ctrl_t   to streamer ctrl_i
// streamer_flags_i in   hci_streamer_flags_t  from streamer flags_o
// streamer_clear_o out  1                  to streamer clear_i
// owner_o          out  $clog2(NB_REQ)     index of current/last granted requester
// busy_o           out  1                  1 in START or BUSY
// timeout_i        in   TIMEOUT_W          watchdog limit; port exists only with the macro
//
// BEHAVIOUR
// Reset: all outputs are 0 (streamer_ctrl_o = '0); FSM = IDLE; rr_q = 0; cfg_q = '0.
// clear_i:
// - Restores the reset state next cycle.
// - streamer_clear_o = clear_i, combinationally, in the same cycle.
// - An in-flight job is dropped: no done pulse, no error pulse.
// enable_i = 0: all registers hold; job_ready_o = 0; req_start = 0.
// FSM states:
// - IDLE:
//   - Grant when |job_valid_i & streamer_flags_i.ready_start & enable_i.
//   - g = first set bit of job_valid_i, searching from rr_q upward and wrapping modulo NB_REQ.
//   - In the grant cycle: job_ready_o[g] = 1 (the handshake completes), cfg_q <= job_ctrl_i[g].addressgen_ctrl, owner_o <= g, rr_q <= (g+1) mod NB_REQ, go to START.
// - START:
//   - streamer_ctrl_o.req_start = 1 for exactly one enabled cycle, then go to BUSY.
// - BUSY:
//   - On streamer_flags_i.done: job_done_o[owner_q] = 1 on the next cycle (registered), go to IDLE.
// - Throughout START and BUSY, streamer_ctrl_o.addressgen_ctrl = cfg_q and is stable.
//   - cfg_q persists into IDLE until the next grant.
// - Grant-to-req_start latency: 1 cycle. Grant-to-grant minimum: 3 cycles plus the job duration.
// - While a job is in flight, job_ready_o = 0; new offers wait.
// - A valid that drops before its grant is legal: no grant, no state change.
// - Simultaneous valids: only one is granted per IDLE cycle; the others stay pending.
// - done arriving in START is ignored (the streamer cannot finish before it starts).
//
// CONFIGURATION
// Macro HCI_SOURCE_SCHED_TIMEOUT_EN, when defined:
// - Adds port timeout_i and a TIMEOUT_W-bit counter.
// - Counter clears on entry to BUSY and increments on each enabled BUSY cycle; it saturates.
// - If timeout_i != 0 and count == timeout_i before done:
//   - streamer_clear_o = 1 for one cycle.
//   - error_o[owner_q] pulses on the next cycle; no job_done_o.
//   - FSM goes to IDLE.
// - timeout_i == 0 disables the watchdog.
// - done and the timeout in the same cycle: done wins.
// Without the macro: no counter, no timeout_i port; error_o tied to 0; streamer_clear_o = clear_i.
//
// TESTING
// 1. Single job: valid[2], ready_start=1 -> ready[2] same cycle; req_start 1 cycle later; done -> job_done[2] next cycle, owner_o=2.
// 2. All 4 valids held, every job done after 10 cycles -> grant order 0,1,2,3,0; no requester granted twice before the others are served.
// 3. ready_start=0 with valid[1] -> no grant; raise ready_start -> grant within 1 cycle.
// 4. clear_i asserted in BUSY -> streamer_clear_o=1 same cycle; FSM IDLE and all outputs 0 next cycle; no done or error pulse.
// 5. enable_i low for 5 cycles in START -> req_start stays 0; it fires on the first enabled cycle; cfg stays unchanged.
// 6. Macro on, timeout_i=20, done never arrives -> after 20 BUSY cycles, streamer_clear_o pulse, then error_o[owner] pulse; next job accepted.

Source files
------------

// File: rtl/hci_source_job_scheduler_pkg.sv
// Shared descriptor and flag payloads for the source-streamer job scheduler.
package hci_source_job_scheduler_pkg;

    typedef struct packed {
        logic [31:0] base_addr;
        logic [15:0] tot_len;
        logic [15:0] d0_stride;
    } hci_addressgen_ctrl_t;

    typedef struct packed {
        logic                 req_start;
        hci_addressgen_ctrl_t addressgen_ctrl;
    } hci_streamer_ctrl_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } hci_streamer_flags_t;

endpackage

// File: rtl/hci_source_job_scheduler_if.sv
// Requester-side job handshake bundle: offers in, accept/completion/error back.
interface hci_source_job_scheduler_if #(
    parameter int unsigned NB_REQ = 4
);
    import hci_source_job_scheduler_pkg::*;

    logic [NB_REQ-1:0]  job_valid;
    logic [NB_REQ-1:0]  job_ready;
    logic [NB_REQ-1:0]  job_done;
    logic [NB_REQ-1:0]  error;
    hci_streamer_ctrl_t job_ctrl [NB_REQ];

    modport master (output job_valid, job_ctrl, input job_ready, job_done, error);
    modport slave  (input job_valid, job_ctrl, output job_ready, job_done, error);

endinterface

// File: rtl/hci_source_job_scheduler.sv
// Round-robin scheduler sharing one source streamer among NB_REQ requesters.
// Optional watchdog enabled by defining HCI_SOURCE_SCHED_TIMEOUT_EN.
module hci_source_job_scheduler
    import hci_source_job_scheduler_pkg::*;
#(
    parameter int unsigned NB_REQ    = 4,
    parameter int unsigned TIMEOUT_W = 16,
    localparam int unsigned OWNER_W  = $clog2(NB_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        enable_i,
    hci_source_job_scheduler_if.slave   job,
    output hci_streamer_ctrl_t          streamer_ctrl_o,
    input  hci_streamer_flags_t         streamer_flags_i,
    output logic                        streamer_clear_o,
    output logic [OWNER_W-1:0]          owner_o,
    output logic                        busy_o
`ifdef HCI_SOURCE_SCHED_TIMEOUT_EN
    ,
    input  logic [TIMEOUT_W-1:0]        timeout_i
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [OWNER_W-1:0]   rr_q, rr_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    hci_addressgen_ctrl_t cfg_q, cfg_d;
    logic [NB_REQ-1:0]    done_q, done_d;
    logic [NB_REQ-1:0]    err_q, err_d;
    logic [NB_REQ-1:0]    ready_c;
    logic [OWNER_W-1:0]   grant_idx;
    logic                 found;
    logic                 req_start;
    logic                 tmo_hit;
    logic                 tmo_fire;
    int unsigned          idx;

    // First pending requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            idx = (32'(rr_q) + i) % NB_REQ;
            if (!found && job.job_valid[OWNER_W'(idx)]) begin
                found     = 1'b1;
                grant_idx = OWNER_W'(idx);
            end
        end
    end

`ifdef HCI_SOURCE_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q;

    // Watchdog: restarts when the job starts, counts enabled BUSY cycles, saturates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            if (state_q == ST_START) begin
                cnt_q <= '0;
            end else if (state_q == ST_BUSY && cnt_q != '1) begin
                cnt_q <= cnt_q + TIMEOUT_W'(1);
            end
        end
    end

    assign tmo_hit = (timeout_i != '0) && (cnt_q == timeout_i);
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state, grant and pulse decode.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        cfg_d     = cfg_q;
        done_d    = '0;
        err_d     = '0;
        ready_c   = '0;
        req_start = 1'b0;
        tmo_fire  = 1'b0;
        if (clear_i) begin
            state_d = ST_IDLE;
            rr_d    = '0;
            owner_d = '0;
            cfg_d   = '0;
        end else if (enable_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (found && streamer_flags_i.ready_start) begin
                        ready_c[grant_idx] = 1'b1;
                        cfg_d   = job.job_ctrl[grant_idx].addressgen_ctrl;
                        owner_d = grant_idx;
                        rr_d    = (grant_idx == OWNER_W'(NB_REQ - 1)) ? '0
                                                                      : grant_idx + OWNER_W'(1);
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    req_start = 1'b1;
                    state_d   = ST_BUSY;
                end
                ST_BUSY: begin
                    if (streamer_flags_i.done) begin
                        done_d[owner_q] = 1'b1;
                        state_d         = ST_IDLE;
                    end else if (tmo_hit) begin
                        tmo_fire       = 1'b1;
                        err_d[owner_q] = 1'b1;
                        state_d        = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, pointer, descriptor and pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            cfg_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cfg_q   <= cfg_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign job.job_ready                   = ready_c;
    assign job.job_done                    = done_q;
    assign job.error                       = err_q;
    assign streamer_ctrl_o.req_start       = req_start;
    assign streamer_ctrl_o.addressgen_ctrl = cfg_q;
    assign streamer_clear_o                = clear_i | tmo_fire;
    assign owner_o                         = owner_q;
    assign busy_o                          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hci_source_job_scheduler.sv
// Randomized bench for hci_source_job_scheduler against a job-level reference model.
// Exercises the watchdog too when HCI_SOURCE_SCHED_TIMEOUT_EN is defined.
module tb_hci_source_job_scheduler;
    import hci_source_job_scheduler_pkg::*;

    localparam int unsigned NB_REQ    = 4;
    localparam int unsigned TIMEOUT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic enable = 1'b0;
    hci_streamer_ctrl_t  streamer_ctrl;
    hci_streamer_flags_t flags = '0;
    logic                streamer_clear;
    logic [1:0]          owner;
    logic                busy;
    logic [TIMEOUT_W-1:0] timeout = '0;

    hci_source_job_scheduler_if #(.NB_REQ(NB_REQ)) job_if ();

    hci_source_job_scheduler #(.NB_REQ(NB_REQ), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .clear_i          (clear),
        .enable_i         (enable),
        .job              (job_if),
        .streamer_ctrl_o  (streamer_ctrl),
        .streamer_flags_i (flags),
        .streamer_clear_o (streamer_clear),
        .owner_o          (owner),
        .busy_o           (busy)
`ifdef HCI_SOURCE_SCHED_TIMEOUT_EN
        ,
        .timeout_i        (timeout)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Job-level reference: is a job held, has its start been issued, who owns it.
    bit                   m_busy;
    bit                   m_started;
    int                   m_owner;
    int                   m_rr;
    int                   m_bc;
    hci_addressgen_ctrl_t m_cfg;
    logic [NB_REQ-1:0]    m_done;
    logic [NB_REQ-1:0]    m_err;
    logic [NB_REQ-1:0]    granted_mask = '0;

    int p_en, p_clr, p_rs, p_valid, p_drop, p_done;
    bit rec = 0;
    int grant_log[$];

    task automatic model_reset();
        m_busy = 0; m_started = 0; m_owner = 0; m_rr = 0; m_bc = 0;
        m_cfg = '0; m_done = '0; m_err = '0;
    endtask

    task automatic drive_inputs();
        hci_streamer_ctrl_t c;
        enable            = ($urandom % 100) < p_en;
        clear             = ($urandom % 100) < p_clr;
        flags.ready_start = ($urandom % 100) < p_rs;
        flags.done        = ($urandom % 100) < p_done;
        for (int r = 0; r < NB_REQ; r++) begin
            if (granted_mask[r]) job_if.job_valid[r] = 1'b0;
            else if (job_if.job_valid[r] && (($urandom % 100) < p_drop)) job_if.job_valid[r] = 1'b0;
            if (!job_if.job_valid[r] && (($urandom % 100) < p_valid)) begin
                c.req_start       = 1'($urandom % 2);
                c.addressgen_ctrl = hci_addressgen_ctrl_t'({$urandom, $urandom});
                job_if.job_ctrl[r]  = c;
                job_if.job_valid[r] = 1'b1;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        logic [NB_REQ-1:0] exp_ready;
        bit exp_rs, fire;
        int g, ix;
        for (int k = 0; k < n; k++) begin
            drive_inputs();
            @(negedge clk);
            exp_ready = '0; exp_rs = 0; fire = 0; g = -1;
            if (!clear) begin
                if (!m_busy) begin
                    if (enable && flags.ready_start) begin
                        for (int i = 0; i < NB_REQ; i++) begin
                            ix = (m_rr + i) % NB_REQ;
                            if (g < 0 && job_if.job_valid[ix]) g = ix;
                        end
                        if (g >= 0) exp_ready[g] = 1'b1;
                    end
                end else if (!m_started) begin
                    exp_rs = enable;
                end else begin
`ifdef HCI_SOURCE_SCHED_TIMEOUT_EN
                    if (enable && !flags.done && timeout != 0 && m_bc == int'(timeout)) fire = 1;
`endif
                end
            end
            check_val("job_ready", job_if.job_ready, exp_ready);
            check_val("req_start", streamer_ctrl.req_start, exp_rs);
            check_val("addr_cfg", streamer_ctrl.addressgen_ctrl, m_cfg);
            check_val("streamer_clear", streamer_clear, clear | fire);
            check_val("job_done", job_if.job_done, m_done);
            check_val("error", job_if.error, m_err);
            check_val("owner", owner, m_owner);
            check_val("busy", busy, m_busy);
            if (rec && job_if.job_ready != '0) begin
                for (int i = 0; i < NB_REQ; i++)
                    if (job_if.job_ready[i]) grant_log.push_back(i);
            end
            m_done = '0; m_err = '0;
            granted_mask = exp_ready;
            if (clear) begin
                model_reset();
            end else if (enable) begin
                if (!m_busy) begin
                    if (g >= 0) begin
                        m_busy = 1; m_started = 0; m_owner = g;
                        m_cfg = job_if.job_ctrl[g].addressgen_ctrl;
                        m_rr = (g + 1) % NB_REQ;
                    end
                end else if (!m_started) begin
                    m_started = 1; m_bc = 0;
                end else if (flags.done) begin
                    m_done[m_owner] = 1'b1; m_busy = 0;
                end else if (fire) begin
                    m_err[m_owner] = 1'b1; m_busy = 0;
                end else if (m_bc < 65535) begin
                    m_bc++;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        model_reset();
        job_if.job_valid = '0;
        for (int r = 0; r < NB_REQ; r++) job_if.job_ctrl[r] = '0;
        repeat (3) @(negedge clk);
        job_if.job_valid = '1;
        #1;
        check_val("rst_ready", job_if.job_ready, 0);
        check_val("rst_ctrl", streamer_ctrl, 0);
        check_val("rst_done", job_if.job_done, 0);
        check_val("rst_error", job_if.error, 0);
        check_val("rst_clear", streamer_clear, 0);
        check_val("rst_owner", owner, 0);
        check_val("rst_busy", busy, 0);
        job_if.job_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All requesters always pending: service must rotate 0,1,2,3,0,...
        p_en = 100; p_clr = 0; p_rs = 100; p_valid = 100; p_drop = 0; p_done = 10;
        rec = 1;
        run_cycles(200);
        rec = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < grant_log.size()) check_val("rr_order", grant_log[i], i % NB_REQ);
            else check_val("rr_count", grant_log.size(), 8);
        end

        // Fully random traffic with stalls, clears, drops and spurious done.
        p_en = 85; p_clr = 2; p_rs = 70; p_valid = 30; p_drop = 5; p_done = 25;
        run_cycles(2500);

`ifdef HCI_SOURCE_SCHED_TIMEOUT_EN
        // Streamer never finishes: every job must end on the watchdog.
        timeout = 16'd20;
        p_en = 100; p_clr = 0; p_rs = 100; p_valid = 50; p_drop = 0; p_done = 0;
        run_cycles(300);
        p_en = 85; p_clr = 1; p_rs = 70; p_valid = 30; p_drop = 5; p_done = 6;
        for (int b = 0; b < 10; b++) begin
            timeout = 16'($urandom_range(0, 8));
            run_cycles(150);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
